// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_pkg
//  Description : Shared definitions for the VGA framebuffer arbiter slice:
//                default widths, requester tags, swap FSM encoding and a
//                page-select helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_fb_pkg;

    // Default geometry: 14-bit pixel address per page, 3-bit RGB pixel
    localparam int ADDR_W_DEF        = 14;
    localparam int DATA_W_DEF        = 3;
    localparam int HOST_WAIT_MAX_DEF = 64;

    // Requester tags carried with each RAM access
    localparam logic TAG_DISP = 1'b0;
    localparam logic TAG_HOST = 1'b1;

    // Double-buffer swap sequencer states
    typedef enum logic [0:0] {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    // The display always reads the shown page; the host owns the other one
    function automatic logic page_sel(input logic tag, input logic shown_page);
        return (tag == TAG_HOST) ? ~shown_page : shown_page;
    endfunction

endpackage : vga_fb_pkg
`default_nettype wire

// File: rtl/vga_fb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_rr_arb
//  Description : Two-way grant logic for the framebuffer RAM port.
//                With i_prio_disp=1 the display has absolute priority;
//                otherwise conflicts are resolved round-robin using a
//                last-grant register. Grants are combinational.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_prio_disp     - 1 = display has fixed priority
//                i_disp_req      - display request
//                i_host_req      - host request
//                o_disp_gnt      - display granted this cycle
//                o_host_gnt      - host granted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_rr_arb
    import vga_fb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_prio_disp,
    input  logic i_disp_req,
    input  logic i_host_req,
    output logic o_disp_gnt,
    output logic o_host_gnt
);

    logic r_last_gnt;

    always_comb begin
        o_disp_gnt = 1'b0;
        o_host_gnt = 1'b0;
        if (i_prio_disp) begin
            o_disp_gnt = i_disp_req;
            o_host_gnt = i_host_req & ~i_disp_req;
        end else if (i_disp_req && i_host_req) begin
            // Conflict: the requester that was not served last goes first
            if (r_last_gnt == TAG_HOST) begin
                o_disp_gnt = 1'b1;
            end else begin
                o_host_gnt = 1'b1;
            end
        end else begin
            o_disp_gnt = i_disp_req;
            o_host_gnt = i_host_req;
        end
    end

    // History tracks every grant, including those made in priority mode,
    // so blanking starts out fair relative to the last active-video grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= TAG_HOST;
        end else if (o_disp_gnt) begin
            r_last_gnt <= TAG_DISP;
        end else if (o_host_gnt) begin
            r_last_gnt <= TAG_HOST;
        end
    end

endmodule : vga_fb_rr_arb
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter
//  Description : Shares one single-port framebuffer RAM between the VGA
//                pixel fetch and a host writer/reader, with double-buffer
//                page swaps applied only at frame boundaries and a sticky
//                host starvation flag.
//                Pipeline: grant N, RAM command N+1, RAM data N+2,
//                registered read return N+3.
//  Ports       : clk, rst_n                     - clock, async active-low reset
//                disp_active, frame_start       - video timing inputs
//                disp_req/addr, disp_ack,
//                disp_rdata/rvalid              - display fetch port
//                host_req/we/addr/wdata,
//                host_ack, host_rdata/rvalid    - host port
//                swap_req, swap_pending,
//                swap_done, disp_page           - page flip control/status
//                host_starved, starved_clr      - starvation flag
//                ram_en/we/addr/wdata, ram_rdata- framebuffer RAM port
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int HOST_WAIT_MAX = HOST_WAIT_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_active,
    input  logic              frame_start,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              disp_page,
    output logic              host_starved,
    input  logic              starved_clr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                 c_CNT_W    = $clog2(HOST_WAIT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(HOST_WAIT_MAX);
    localparam logic [c_CNT_W-1:0] c_WAIT_SET = c_CNT_W'(HOST_WAIT_MAX - 1);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic w_disp_gnt;
    logic w_host_gnt;

    vga_fb_rr_arb u_rr_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_prio_disp (disp_active),
        .i_disp_req  (disp_req),
        .i_host_req  (host_req),
        .o_disp_gnt  (w_disp_gnt),
        .o_host_gnt  (w_host_gnt)
    );

    assign disp_ack = w_disp_gnt;
    assign host_ack = w_host_gnt;

    // ------------------------------------------------------------------
    // Stage 1: RAM command, page sampled at grant time
    // ------------------------------------------------------------------
    logic              r_disp_page;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W:0]   r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_s1_tag;
    logic              r_s1_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_s1_tag    <= TAG_DISP;
            r_s1_rd     <= 1'b0;
        end else begin
            r_ram_en    <= w_disp_gnt | w_host_gnt;
            r_ram_we    <= w_host_gnt & host_we;
            r_s1_rd     <= w_disp_gnt | (w_host_gnt & ~host_we);
            r_s1_tag    <= w_host_gnt ? TAG_HOST : TAG_DISP;
            r_ram_wdata <= (w_host_gnt & host_we) ? host_wdata : '0;
            if (w_disp_gnt) begin
                r_ram_addr <= {page_sel(TAG_DISP, r_disp_page), disp_addr};
            end else if (w_host_gnt) begin
                r_ram_addr <= {page_sel(TAG_HOST, r_disp_page), host_addr};
            end else begin
                r_ram_addr <= '0;
            end
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

    // ------------------------------------------------------------------
    // Stage 2: RAM data cycle; Stage 3: registered read return
    // ------------------------------------------------------------------
    logic              r_s2_tag;
    logic              r_s2_rd;
    logic              r_disp_rvalid;
    logic [DATA_W-1:0] r_disp_rdata;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_tag      <= TAG_DISP;
            r_s2_rd       <= 1'b0;
            r_disp_rvalid <= 1'b0;
            r_disp_rdata  <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_s2_tag      <= r_s1_tag;
            r_s2_rd       <= r_s1_rd;
            r_disp_rvalid <= r_s2_rd & (r_s2_tag == TAG_DISP);
            r_host_rvalid <= r_s2_rd & (r_s2_tag == TAG_HOST);
            if (r_s2_rd && (r_s2_tag == TAG_DISP)) begin
                r_disp_rdata <= ram_rdata;
            end
            if (r_s2_rd && (r_s2_tag == TAG_HOST)) begin
                r_host_rdata <= ram_rdata;
            end
        end
    end

    assign disp_rvalid = r_disp_rvalid;
    assign disp_rdata  = r_disp_rdata;
    assign host_rvalid = r_host_rvalid;
    assign host_rdata  = r_host_rdata;

    // ------------------------------------------------------------------
    // Page swap sequencer
    // ------------------------------------------------------------------
    swap_state_t r_swap_state;
    swap_state_t w_swap_state_nxt;
    logic        w_flip;
    logic        r_swap_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swap_state <= SWAP_IDLE;
        end else begin
            r_swap_state <= w_swap_state_nxt;
        end
    end

    // A frame_start seen in IDLE never flips, even if swap_req arrives in
    // the same cycle: the request then waits for the next frame boundary.
    always_comb begin
        w_swap_state_nxt = r_swap_state;
        w_flip           = 1'b0;
        case (r_swap_state)
            SWAP_IDLE: begin
                if (swap_req) begin
                    w_swap_state_nxt = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (frame_start) begin
                    w_swap_state_nxt = SWAP_IDLE;
                    w_flip           = 1'b1;
                end
            end
            default: begin
                w_swap_state_nxt = SWAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_page <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_disp_page <= r_disp_page ^ w_flip;
            r_swap_done <= w_flip;
        end
    end

    assign swap_pending = (r_swap_state == SWAP_PENDING);
    assign swap_done    = r_swap_done;
    assign disp_page    = r_disp_page;

    // ------------------------------------------------------------------
    // Host starvation monitor
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_host_starved;
    logic               w_host_wait;
    logic               w_starve_set;

    assign w_host_wait  = host_req & ~w_host_gnt;
    // Set in the same cycle the counter steps onto (or sits at) the limit
    assign w_starve_set = w_host_wait & (r_wait_cnt >= c_WAIT_SET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_host_gnt) begin
            r_wait_cnt <= '0;
        end else if (w_host_wait && (r_wait_cnt != c_WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_host_starved <= 1'b0;
        end else if (w_starve_set) begin
            r_host_starved <= 1'b1;
        end else if (starved_clr) begin
            r_host_starved <= 1'b0;
        end
    end

    assign host_starved = r_host_starved;

endmodule : vga_fb_arbiter
`default_nettype wire
